// File: rtl/grf_writeback.sv
// GRF write-port arbiter: merges M-stage results with buffered late results and tracks
// outstanding late writes. Define GRF_WB_LATE_BYPASS_EN to let late results skip the FIFO.
module grf_writeback #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned PTR_W      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  m_a3,
  input  logic [31:0] m_wd,
  input  logic [31:0] m_pc,
  input  logic        late_issue_valid,
  input  logic [4:0]  late_issue_reg,
  input  logic        late_valid,
  output logic        late_ready,
  input  logic [4:0]  late_a3,
  input  logic [31:0] late_wd,
  input  logic [31:0] late_pc,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  output logic [31:0] pending_mask
);

  localparam logic [PTR_W:0]   DepthCnt = FIFO_DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] PtrOne   = PTR_W'(1);
  localparam logic [PTR_W:0]   CntOne   = (PTR_W + 1)'(1);

  logic [4:0]       fifo_a3 [FIFO_DEPTH];
  logic [31:0]      fifo_wd [FIFO_DEPTH];
  logic [31:0]      fifo_pc [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;

  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mask_q, mask_d;

  logic accept, has_m, fifo_empty, pop, push, bypass;
  logic [31:0] set_vec, clr_vec;

  assign late_ready = (count_q < DepthCnt);
  assign accept     = late_valid && late_ready;
  assign has_m      = (m_a3 != 5'd0);
  assign fifo_empty = (count_q == '0);
  assign pop        = !has_m && !fifo_empty;

`ifdef GRF_WB_LATE_BYPASS_EN
  assign bypass = !has_m && fifo_empty && accept && (late_a3 != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // Results to $0 are accepted but dropped on the floor.
  assign push = accept && (late_a3 != 5'd0) && !bypass;

  always_comb begin
    a3_d = 5'd0;
    wd_d = 32'd0;
    pc_d = 32'd0;
    clr_vec = 32'd0;
    if (has_m) begin
      a3_d = m_a3;
      wd_d = m_wd;
      pc_d = m_pc;
    end else if (pop) begin
      a3_d = fifo_a3[rd_ptr_q];
      wd_d = fifo_wd[rd_ptr_q];
      pc_d = fifo_pc[rd_ptr_q];
      clr_vec[fifo_a3[rd_ptr_q]] = 1'b1;
    end else if (bypass) begin
      a3_d = late_a3;
      wd_d = late_wd;
      pc_d = late_pc;
      clr_vec[late_a3] = 1'b1;
    end
  end

  always_comb begin
    set_vec = 32'd0;
    if (late_issue_valid) set_vec[late_issue_reg] = 1'b1;
    // Set applied after clear so a same-cycle reissue keeps the bit.
    mask_d = ((mask_q & ~clr_vec) | set_vec) & ~32'h1;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + CntOne;
    else if (pop && !push) count_d = count_q - CntOne;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a3_q     <= 5'd0;
      wd_q     <= 32'd0;
      pc_q     <= 32'd0;
      mask_q   <= 32'd0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      a3_q    <= a3_d;
      wd_q    <= wd_d;
      pc_q    <= pc_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a3[wr_ptr_q] <= late_a3;
      fifo_wd[wr_ptr_q] <= late_wd;
      fifo_pc[wr_ptr_q] <= late_pc;
    end
  end

  assign grf_a3       = a3_q;
  assign grf_wd       = wd_q;
  assign grf_pc       = pc_q;
  assign pending_mask = mask_q;

endmodule

// File: tb/tb_grf_writeback.sv
// Directed self-checking bench for grf_writeback; expectations follow GRF_WB_LATE_BYPASS_EN.
module tb_grf_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  m_a3;
  logic [31:0] m_wd, m_pc;
  logic        late_issue_valid;
  logic [4:0]  late_issue_reg;
  logic        late_valid, late_ready;
  logic [4:0]  late_a3;
  logic [31:0] late_wd, late_pc;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc, pending_mask;

  int n_checks = 0;
  int n_fail   = 0;

  grf_writeback #(.FIFO_DEPTH(2), .PTR_W(1)) dut (
    .clk              (clk),
    .reset            (reset),
    .m_a3             (m_a3),
    .m_wd             (m_wd),
    .m_pc             (m_pc),
    .late_issue_valid (late_issue_valid),
    .late_issue_reg   (late_issue_reg),
    .late_valid       (late_valid),
    .late_ready       (late_ready),
    .late_a3          (late_a3),
    .late_wd          (late_wd),
    .late_pc          (late_pc),
    .grf_a3           (grf_a3),
    .grf_wd           (grf_wd),
    .grf_pc           (grf_pc),
    .pending_mask     (pending_mask)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_a3 = 5'd0; m_wd = 32'd0; m_pc = 32'd0;
    late_issue_valid = 1'b0; late_issue_reg = 5'd0;
    late_valid = 1'b0; late_a3 = 5'd0; late_wd = 32'd0; late_pc = 32'd0;
  endtask

  task automatic issue(input logic [4:0] r);
    late_issue_valid = 1'b1; late_issue_reg = r;
    step();
    late_issue_valid = 1'b0; late_issue_reg = 5'd0;
  endtask

  task automatic offer(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    late_valid = 1'b1; late_a3 = a3; late_wd = wd; late_pc = pc;
  endtask

  task automatic no_offer();
    late_valid = 1'b0; late_a3 = 5'd0; late_wd = 32'd0; late_pc = 32'd0;
  endtask

  // Fills the FIFO with $9/$10 while M-stage writes hold the port.
  task automatic fill_under_m();
    m_a3 = 5'd1; m_wd = 32'h11; m_pc = 32'h5000;
    offer(5'd9, 32'h99, 32'h6000);
    step();
    check_eq("ready_after_1st", {31'd0, late_ready}, 32'd1);
    offer(5'd10, 32'h1010, 32'h6004);
    step();
    no_offer();
    check_eq("ready_after_2nd", {31'd0, late_ready}, 32'd0);
    check_eq("m_holds_port", {27'd0, grf_a3}, 32'd1);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #12;
    check_eq("rst_a3", {27'd0, grf_a3}, 32'd0);
    check_eq("rst_wd", grf_wd, 32'd0);
    check_eq("rst_pc", grf_pc, 32'd0);
    check_eq("rst_mask", pending_mask, 32'd0);
    check_eq("rst_ready", {31'd0, late_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    step();

    // M-stage write, one cycle latency
    m_a3 = 5'd5; m_wd = 32'h1234; m_pc = 32'h3000;
    step();
    m_a3 = 5'd0; m_wd = 32'd0; m_pc = 32'd0;
    check_eq("m_a3", {27'd0, grf_a3}, 32'd5);
    check_eq("m_wd", grf_wd, 32'h1234);
    check_eq("m_pc", grf_pc, 32'h3000);
    step();
    check_eq("idle_a3", {27'd0, grf_a3}, 32'd0);

    // Late result to $8
    issue(5'd8);
    check_eq("mask_8_set", pending_mask, 32'h100);
    offer(5'd8, 32'hAA, 32'h4000);
    check_eq("ready_empty", {31'd0, late_ready}, 32'd1);
    step();
    no_offer();
`ifndef GRF_WB_LATE_BYPASS_EN
    check_eq("late8_not_yet", {27'd0, grf_a3}, 32'd0);
    check_eq("mask_8_held", pending_mask, 32'h100);
    step();
`endif
    check_eq("late8_a3", {27'd0, grf_a3}, 32'd8);
    check_eq("late8_wd", grf_wd, 32'hAA);
    check_eq("late8_pc", grf_pc, 32'h4000);
    check_eq("mask_8_clr", pending_mask, 32'h0);

    // Starvation and in-order drain
    issue(5'd9);
    issue(5'd10);
    check_eq("mask_9_10", pending_mask, 32'h600);
    fill_under_m();
    m_wd = 32'h22;
    step();
    m_wd = 32'h33;
    step();
    check_eq("starve_ready", {31'd0, late_ready}, 32'd0);
    check_eq("starve_wd", grf_wd, 32'h33);
    check_eq("starve_mask", pending_mask, 32'h600);
    m_a3 = 5'd0; m_wd = 32'd0; m_pc = 32'd0;
    step();
    check_eq("drain1_a3", {27'd0, grf_a3}, 32'd9);
    check_eq("drain1_wd", grf_wd, 32'h99);
    check_eq("drain1_mask", pending_mask, 32'h400);
    check_eq("drain1_ready", {31'd0, late_ready}, 32'd1);
    step();
    check_eq("drain2_a3", {27'd0, grf_a3}, 32'd10);
    check_eq("drain2_pc", grf_pc, 32'h6004);
    check_eq("drain2_mask", pending_mask, 32'h0);
    step();
    check_eq("drain_done", {27'd0, grf_a3}, 32'd0);

    // Asynchronous reset with a full FIFO
    issue(5'd9);
    issue(5'd10);
    fill_under_m();
    check_eq("pre_rst_mask", pending_mask, 32'h600);
    #2 reset = 1'b1;
    #1;
    check_eq("async_a3", {27'd0, grf_a3}, 32'd0);
    check_eq("async_wd", grf_wd, 32'd0);
    check_eq("async_mask", pending_mask, 32'd0);
    check_eq("async_ready", {31'd0, late_ready}, 32'd1);
    m_a3 = 5'd0; m_wd = 32'd0; m_pc = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    step();
    check_eq("post_rst_empty", {27'd0, grf_a3}, 32'd0);
    step();
    check_eq("post_rst_empty2", {27'd0, grf_a3}, 32'd0);

    // Set wins over clear on $12
    issue(5'd12);
    check_eq("mask_12", pending_mask, 32'h1000);
    offer(5'd12, 32'hC0C0, 32'h7000);
`ifdef GRF_WB_LATE_BYPASS_EN
    late_issue_valid = 1'b1; late_issue_reg = 5'd12;
    step();
`else
    step();
    no_offer();
    late_issue_valid = 1'b1; late_issue_reg = 5'd12;
    step();
`endif
    no_offer();
    late_issue_valid = 1'b0; late_issue_reg = 5'd0;
    check_eq("setwin_a3", {27'd0, grf_a3}, 32'd12);
    check_eq("setwin_mask", pending_mask, 32'h1000);

    // Result to $0 is swallowed
    offer(5'd0, 32'h55, 32'h8000);
    step();
    no_offer();
    check_eq("zero_a3", {27'd0, grf_a3}, 32'd0);
    check_eq("zero_wd", grf_wd, 32'd0);
    check_eq("zero_mask", pending_mask, 32'h1000);
    step();
    check_eq("zero_not_pushed", {27'd0, grf_a3}, 32'd0);
    check_eq("zero_ready", {31'd0, late_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_writeback.md
# grf_writeback

Writer end of the GRF write port. Merges two result sources, the in-order M-stage result and out-of-order late results (multi-cycle MDU or slow load unit), onto the single GRF write port. It keeps a pending-register scoreboard so the hazard unit can stall readers of registers whose late write has not yet committed. It sits in the W stage, between the M/W boundary and the GRF.

## Interface
Parameters:
- FIFO_DEPTH, 2, late-result buffer entries; power of two, ≥2
- PTR_W, 1, log2(FIFO_DEPTH)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- m_a3  in  5  M-stage destination register; 0 means no write
- m_wd  in  32  M-stage write data
- m_pc  in  32  M-stage instruction PC
- late_issue_valid  in  1  a late-completing instruction was issued this cycle
- late_issue_reg  in  5  its destination register
- late_valid  in  1  late result offered
- late_ready  out  1  late result accepted when late_valid && late_ready at posedge
- late_a3  in  5  late result destination
- late_wd  in  32  late result data
- late_pc  in  32  late result PC
- grf_a3  out  5  to GRF A3; GRF write enable is held at 1, and a write occurs iff grf_a3 != 0
- grf_wd  out  32  to GRF WD
- grf_pc  out  32  to GRF PC (trace)
- pending_mask  out  32  bit r set = late write to $r outstanding; bit 0 always 0

## Operation
- Outputs grf_* are registers and are reloaded every cycle. Source priority per cycle:
  1. m_a3 != 0: load m_a3/m_wd/m_pc.
  2. Else, FIFO non-empty: pop the head and load it.
  3. Else, with bypass enabled, late_valid && late_ready: load the late inputs directly, with no FIFO push.
  4. Else: load grf_a3=0, grf_wd=0, grf_pc=0.
- late_ready = (FIFO count < FIFO_DEPTH). It is independent of m_a3.
- An accepted late result is pushed into the FIFO unless it is bypassed (rule 3).
  - Push and pop in the same cycle are legal; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- An accepted late result with late_a3 == 0 is accepted and discarded. It is neither pushed nor written.
- Scoreboard:
  - Set: late_issue_valid && late_issue_reg != 0 sets pending_mask[late_issue_reg] at posedge.
  - Clear: the bit for a late-sourced value is cleared at the posedge that loads it into grf_a3 (rule 2 or 3).
  - Set wins over clear when both target the same register in the same cycle.
  - Issuing a register that is already pending is a protocol violation. The hazard unit prevents it, and the block's behaviour is unspecified.
- M-stage writes never touch pending_mask.
- Ordering: the FIFO is strict FIFO. Late results commit in acceptance order.

## Timing
- Reset values: grf_a3=0, grf_wd=0, grf_pc=0, pending_mask=0, FIFO empty, late_ready=1.
- Reset takes effect asynchronously, including mid-drain. Buffered late results are lost on reset.
- M-stage latency: 1 cycle (m_* at edge n appears on grf_* after edge n).
- Late latency:
  - With bypass and an empty FIFO and m_a3 == 0: 1 cycle.
  - Otherwise: ≥2 cycles, as long as M-stage writes continue to occupy the port.
- Starvation: back-to-back M-stage writes starve the FIFO indefinitely. When the FIFO is full, late_ready=0 and the producer must hold its data.
- late_ready is combinational from the count only. It has no path from late_valid.

## Configuration
- GRF_WB_LATE_BYPASS_EN:
  - Defined: rule 3 is active, and a late result can reach grf_* in 1 cycle without a FIFO round-trip.
  - Undefined: rule 3 is absent. Every accepted late result (late_a3 != 0) is pushed and drained on a later cycle, giving a minimum late latency of 2 cycles.
- Scoreboard and handshake behaviour are otherwise identical in both builds.

## Test plan
- Reset, then m_a3=5, m_wd=0x1234, m_pc=0x3000 → next cycle grf_a3=5, grf_wd=0x1234, grf_pc=0x3000; idle cycle → grf_a3=0.
- late_issue_reg=8, then late result (a3=8, wd=0xAA) with m_a3=0 → pending_mask=0x100 until commit. Commit occurs 1 cycle after accept with bypass and 2 cycles without; mask is 0 after commit.
- m_a3 nonzero for 4 cycles while late results to $9 and $10 arrive → late_ready drops after the second accept. Once m_a3=0, $9 commits, then $10, in order.
- late_issue_reg=12 in the same cycle that a late result for $12 commits → pending_mask[12] remains 1.
- Assert reset while the FIFO holds 2 entries and pending_mask=0x600 → outputs, count and mask go to 0 immediately; late_ready=1.
- Late result with late_a3=0 accepted → no GRF write and pending_mask unchanged.
